// File: rtl/psum_acc_ctrl.sv
// psum_acc_ctrl: partial-sum accumulation controller.
//
// Accumulates cfg_pass_num adder-tree sums per output and emits
// cfg_out_num outputs per job, then pulses done.
//
// Parameters
//   DATA_WID  signed width of the input sums and of out_data (default `CNN_XLEN)
//   PASS_WID  width of the pass-count field; accumulator is DATA_WID+PASS_WID
//   OUT_WID   width of the output-count field
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   cfg_start               one-cycle job start (honoured in IDLE only)
//   cfg_pass_num            sums per output (0 is treated as 1)
//   cfg_out_num             outputs per job (0 finishes at once)
//   in_valid/in_ready/in_data      adder-tree sum stream
//   out_valid/out_ready/out_data/out_last  result stream
//   busy                    high whenever the FSM is not IDLE
//   done                    one-cycle job-complete pulse
//   dbg_state               current FSM state
//
// Handshake: a beat transfers on a rising clk edge where valid and ready are
// both 1. A producer holding valid keeps its data stable until that edge;
// out_valid/out_data/out_last are held until out_ready is seen.
//
// Macros
//   CNN_XLEN     default for DATA_WID (16 when not defined elsewhere)
//   PSUM_SAT_EN  saturate out_data to the signed DATA_WID range; when not
//                defined, out_data is the low DATA_WID accumulator bits.

`ifndef CNN_XLEN
`define CNN_XLEN 16
`endif

module psum_acc_ctrl #(
  parameter int DATA_WID = `CNN_XLEN,
  parameter int PASS_WID = 4,
  parameter int OUT_WID  = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_start,
  input  logic [PASS_WID-1:0]        cfg_pass_num,
  input  logic [OUT_WID-1:0]         cfg_out_num,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_WID-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [DATA_WID-1:0] out_data,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 dbg_state
);

  localparam int ACC_WID = DATA_WID + PASS_WID;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_OUTPUT = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_next_state;
  logic signed [ACC_WID-1:0]  r_acc;
  logic [PASS_WID-1:0]        r_pass_cnt;
  logic [PASS_WID-1:0]        r_pass_num;
  logic [OUT_WID-1:0]         r_out_idx;
  logic [OUT_WID-1:0]         r_out_num;
  logic                       r_done;

  logic                       w_in_fire;
  logic                       w_out_fire;
  logic [PASS_WID-1:0]        w_pass_last;
  logic                       w_pass_done;
  logic                       w_last_out;
  logic signed [ACC_WID-1:0]  w_in_ext;
  logic [DATA_WID-1:0]        w_result;

  // Index of the final pass; a latched pass count of 0 behaves as 1.
  assign w_pass_last = (r_pass_num == '0) ? '0 : r_pass_num - PASS_WID'(1);
  assign w_in_fire   = (r_state == S_ACCUM) && in_valid;
  assign w_out_fire  = (r_state == S_OUTPUT) && out_ready;
  assign w_pass_done = w_in_fire && (r_pass_cnt == w_pass_last);
  assign w_last_out  = (r_out_idx == (r_out_num - OUT_WID'(1)));
  assign w_in_ext    = {{PASS_WID{in_data[DATA_WID-1]}}, in_data};

`ifdef PSUM_SAT_EN
  // The accumulator fits the output range only when every bit from the
  // output sign bit upward agrees.
  logic [PASS_WID:0] w_acc_hi;
  logic              w_in_range;
  assign w_acc_hi   = r_acc[ACC_WID-1:DATA_WID-1];
  assign w_in_range = (&w_acc_hi) | ~(|w_acc_hi);
  assign w_result   = w_in_range ? r_acc[DATA_WID-1:0] :
                      r_acc[ACC_WID-1] ? {1'b1, {(DATA_WID-1){1'b0}}} :
                                         {1'b0, {(DATA_WID-1){1'b1}}};
`else
  assign w_result   = r_acc[DATA_WID-1:0];
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        // A zero-output job completes without ever leaving IDLE.
        if (cfg_start && (cfg_out_num != '0)) begin
          w_next_state = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (w_pass_done) begin
          w_next_state = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (w_out_fire) begin
          w_next_state = w_last_out ? S_IDLE : S_ACCUM;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath: accumulator, counters, latched configuration and done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc      <= '0;
      r_pass_cnt <= '0;
      r_pass_num <= '0;
      r_out_idx  <= '0;
      r_out_num  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cfg_start) begin
            r_pass_num <= cfg_pass_num;
            r_out_num  <= cfg_out_num;
            r_acc      <= '0;
            r_pass_cnt <= '0;
            r_out_idx  <= '0;
            if (cfg_out_num == '0) begin
              r_done <= 1'b1;
            end
          end
        end
        S_ACCUM: begin
          if (w_in_fire) begin
            r_acc      <= r_acc + w_in_ext;
            r_pass_cnt <= r_pass_cnt + PASS_WID'(1);
          end
        end
        S_OUTPUT: begin
          if (w_out_fire) begin
            r_acc      <= '0;
            r_pass_cnt <= '0;
            if (w_last_out) begin
              r_done <= 1'b1;
            end else begin
              r_out_idx <= r_out_idx + OUT_WID'(1);
            end
          end
        end
        default: begin
          r_acc <= '0;
        end
      endcase
    end
  end

  // Outputs are decoded from state so they fall to 0 as soon as reset hits.
  assign in_ready  = (r_state == S_ACCUM);
  assign out_valid = (r_state == S_OUTPUT);
  assign out_last  = (r_state == S_OUTPUT) && w_last_out;
  assign out_data  = (r_state == S_OUTPUT) ? w_result : '0;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_psum_acc_ctrl.sv
// Directed testbench for psum_acc_ctrl (DATA_WID=16, PASS_WID=4, OUT_WID=10).
module tb_psum_acc_ctrl;

  localparam int DW = 16;
  localparam int PW = 4;
  localparam int OW = 10;

`ifdef PSUM_SAT_EN
  localparam int EXP_POS = 32767;
  localparam int EXP_NEG = -32768;
`else
  localparam int EXP_POS = 24464;   // 90000 mod 65536
  localparam int EXP_NEG = -24464;  // -90000 wrapped to 16 bits
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 cfg_start;
  logic [PW-1:0]        cfg_pass_num;
  logic [OW-1:0]        cfg_out_num;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;
  logic                 out_last;
  logic                 busy;
  logic                 done;
  logic [1:0]           dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic signed [DW-1:0] exp_q[$];

  psum_acc_ctrl #(.DATA_WID(DW), .PASS_WID(PW), .OUT_WID(OW)) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_start    (cfg_start),
    .cfg_pass_num (cfg_pass_num),
    .cfg_out_num  (cfg_out_num),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done),
    .dbg_state    (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic start(input int p, input int o);
    cfg_start    = 1'b1;
    cfg_pass_num = PW'(p);
    cfg_out_num  = OW'(o);
    tick();
    cfg_start    = 1'b0;
  endtask

  // Presents one sum and leaves in_valid high so consecutive calls stream.
  task automatic send_sum(input int d);
    in_valid = 1'b1;
    in_data  = DW'(d);
    for (int i = 0; i < 20 && !in_ready; i++) tick();
    check("in_ready_wait", 32'(in_ready), 32'd1);
    tick();
  endtask

  // Waits for an output, checks it against the scoreboard and accepts it.
  task automatic take_out(input logic exp_last);
    logic signed [DW-1:0] e;
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    check("out_valid_wait", 32'(out_valid), 32'd1);
    e = exp_q.pop_front();
    check("out_data", out_data, e);
    check("out_last", 32'(out_last), 32'(exp_last));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic check_done_pulse(input string tag);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset
    reset = 1'b1; cfg_start = 1'b0; cfg_pass_num = '0; cfg_out_num = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) tick();
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  out_data,       32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_state",     32'(dbg_state), 32'd0);
    reset = 1'b0;
    tick();

    // Basic: pass=4, out=1, sums 10,-3,7,1 held back-to-back
    start(4, 1);
    check("basic_busy", 32'(busy), 32'd1);
    send_sum(10); send_sum(-3); send_sum(7); send_sum(1);
    check("basic_latency", 32'(out_valid), 32'd1);
    exp_q.push_back(DW'(15));
    take_out(1'b1);
    check_done_pulse("basic");
    tick();
    check("basic_done_one_cycle", 32'(done), 32'd0);

    // Backpressure: pass=2, out=3, in_valid pushed against a stalled output
    start(2, 3);
    send_sum(1); send_sum(2);
    in_valid = 1'b1; in_data = DW'(777);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data",  out_data,       32'd3);
      check("bp_out_last",  32'(out_last),  32'd0);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      tick();
    end
    exp_q.push_back(DW'(3));
    take_out(1'b0);
    send_sum(-4); send_sum(-5);
    exp_q.push_back(DW'(-9));
    take_out(1'b0);
    send_sum(100); send_sum(200);
    exp_q.push_back(DW'(300));
    take_out(1'b1);
    check_done_pulse("bp");
    tick();

    // Saturation / wrap: pass=3, out=2
    start(3, 2);
    send_sum(30000); send_sum(30000); send_sum(30000);
    exp_q.push_back(DW'(EXP_POS));
    take_out(1'b0);
    send_sum(-30000); send_sum(-30000); send_sum(-30000);
    exp_q.push_back(DW'(EXP_NEG));
    take_out(1'b1);
    check_done_pulse("sat");
    tick();

    // pass=0 behaves as 1; then a zero-output job started the cycle after done
    start(0, 1);
    send_sum(5);
    check("pass0_single_transfer", 32'(out_valid), 32'd1);
    exp_q.push_back(DW'(5));
    take_out(1'b1);
    check_done_pulse("pass0");
    start(3, 0);
    check("out0_done",     32'(done),      32'd1);
    check("out0_no_valid", 32'(out_valid), 32'd0);
    check("out0_not_busy", 32'(busy),      32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("out0_done_clear", 32'(done),      32'd0);
      check("out0_valid_low",  32'(out_valid), 32'd0);
    end

    // Reset during the 2nd pass of the 2nd output
    start(3, 2);
    send_sum(1); send_sum(1); send_sum(1);
    exp_q.push_back(DW'(3));
    take_out(1'b0);
    send_sum(1);
    in_valid = 1'b1; in_data = DW'(2);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_in_ready",  32'(in_ready),  32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data",  out_data,       32'd0);
    check("mid_rst_busy",      32'(busy),      32'd0);
    check("mid_rst_done",      32'(done),      32'd0);
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
    check("post_rst_done", 32'(done), 32'd0);
    start(1, 1);
    check("post_rst_start", 32'(busy), 32'd1);
    send_sum(-7);
    exp_q.push_back(DW'(-7));
    take_out(1'b1);
    check_done_pulse("post_rst");
    tick();

    // cfg_start while busy is ignored
    start(2, 2);
    cfg_start = 1'b1; cfg_pass_num = PW'(1); cfg_out_num = OW'(1);
    send_sum(1);
    check("busy_start_accum", 32'(out_valid), 32'd0);
    send_sum(2);
    tick();
    check("busy_start_hold", out_data, 32'd3);
    cfg_start = 1'b0;
    exp_q.push_back(DW'(3));
    take_out(1'b0);
    send_sum(4);
    check("busy_start_pass_kept", 32'(out_valid), 32'd0);
    send_sum(5);
    exp_q.push_back(DW'(9));
    take_out(1'b1);
    check_done_pulse("busy_start");
    tick();
    check("final_idle", 32'(busy), 32'd0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
